// File: rtl/alu_iter_seq_if.sv
// Bundles the command/result handshake and the shared-ALU borrow port of alu_iter_seq.
// master = requester/pipeline side, slave = the sequencer itself.
interface alu_iter_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cmd;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             alu_req;
  logic             alu_gnt;
  logic [WIDTH-1:0] alu_in_0;
  logic [WIDTH-1:0] alu_in_1;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_out;

  modport master (
    output start, cmd, opa, opb, alu_gnt, alu_out,
    input  busy, done, result, remainder, div_zero, alu_req, alu_in_0, alu_in_1, alu_op
  );

  modport slave (
    input  start, cmd, opa, opb, alu_gnt, alu_out,
    output busy, done, result, remainder, div_zero, alu_req, alu_in_0, alu_in_1, alu_op
  );
endinterface

// File: rtl/alu_iter_seq.sv
// Iterative unsigned multiply (low word) / restoring divide that borrows the shared
// ALU for one add or subtract per granted cycle.
module alu_iter_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  alu_iter_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] ALU_OP_NOP  = 4'h0;
  localparam logic [3:0] ALU_OP_ADDU = 4'h1;
  localparam logic [3:0] ALU_OP_SUBU = 4'h2;

  logic [1:0]       state_reg;
  logic             cmd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] acc_reg, mc_reg, mp_reg;
  logic [WIDTH-1:0] q_reg, rem_reg, d_reg;
  logic [WIDTH-1:0] result_reg, remainder_reg;
  logic             div_zero_reg;

  logic [WIDTH:0]   div_t;
  logic             div_ge;
  logic [WIDTH-1:0] acc_next, mc_next, mp_next, rem_next, q_next;
  logic             last_iter;

  // div_t carries rem's MSB as an extra bit so the trial compare never wraps.
  always_comb begin
    div_t     = {rem_reg, q_reg[WIDTH-1]};
    div_ge    = (div_t >= {1'b0, d_reg});
    acc_next  = mp_reg[0] ? bus.alu_out : acc_reg;
    mc_next   = mc_reg << 1;
    mp_next   = mp_reg >> 1;
    rem_next  = div_ge ? bus.alu_out : div_t[WIDTH-1:0];
    q_next    = {q_reg[WIDTH-2:0], div_ge};
    last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    bus.alu_in_0 = '0;
    bus.alu_in_1 = '0;
    bus.alu_op   = ALU_OP_NOP;
    if (state_reg == ST_RUN) begin
      if (cmd_reg) begin
        bus.alu_in_0 = div_t[WIDTH-1:0];
        bus.alu_in_1 = d_reg;
        bus.alu_op   = ALU_OP_SUBU;
      end else begin
        bus.alu_in_0 = acc_reg;
        bus.alu_in_1 = mc_reg;
        bus.alu_op   = ALU_OP_ADDU;
      end
    end
  end

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = (state_reg == ST_DONE);
  assign bus.alu_req   = (state_reg == ST_RUN);
  assign bus.result    = result_reg;
  assign bus.remainder = remainder_reg;
  assign bus.div_zero  = div_zero_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cmd_reg       <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      mc_reg        <= '0;
      mp_reg        <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      d_reg         <= '0;
      result_reg    <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            cmd_reg      <= bus.cmd;
            cnt_reg      <= '0;
            div_zero_reg <= 1'b0;
            acc_reg      <= '0;
            mc_reg       <= bus.opa;
            mp_reg       <= bus.opb;
            q_reg        <= bus.opa;
            rem_reg      <= '0;
            d_reg        <= bus.opb;
            if (bus.cmd && (bus.opb == '0)) begin
              result_reg    <= '1;
              remainder_reg <= bus.opa;
              div_zero_reg  <= 1'b1;
              state_reg     <= ST_DONE;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Ungranted cycles hold everything; the pipeline owns the ALU then.
          if (bus.alu_gnt) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cmd_reg) begin
              rem_reg <= rem_next;
              q_reg   <= q_next;
            end else begin
              acc_reg <= acc_next;
              mc_reg  <= mc_next;
              mp_reg  <= mp_next;
            end
            if (last_iter) begin
              result_reg    <= cmd_reg ? q_next : acc_next;
              remainder_reg <= cmd_reg ? rem_next : '0;
              state_reg     <= ST_DONE;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_iter_seq.md
Name: alu_iter_seq

Overview:
Iterative multiply/divide sequencer that borrows the shared 32-bit ALU for one add or subtract per iteration. It computes an unsigned 32x32 multiply (low 32 bits) or an unsigned 32/32 divide (quotient and remainder). It sits beside the EX stage and requests the ALU through a req/gnt handshake; the pipeline owns the ALU whenever gnt is low.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
cmd  input  1  0 = multiply, 1 = divide; sampled with start
opa  input  WIDTH  multiplicand / dividend; sampled with start
opb  input  WIDTH  multiplier / divisor; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  product low word or quotient
remainder  output  WIDTH  divide remainder; 0 after multiply
div_zero  output  1  high with done when divisor was 0
alu_req  output  1  high in RUN
alu_gnt  input  1  ALU granted this cycle
alu_in_0  output  WIDTH  ALU operand 0
alu_in_1  output  WIDTH  ALU operand 1
alu_op  output  4  ALU_OP_ADDU (mul), ALU_OP_SUBU (div), ALU_OP_NOP otherwise
alu_out  input  WIDTH  ALU result (combinational)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, div_zero, alu_req = 0; result, remainder, alu_in_0, alu_in_1 = 0; alu_op = ALU_OP_NOP; counter and internal registers = 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches cmd/opa/opb and clears the counter.
  - Divide with opb=0: go directly to DONE with result=32'hFFFFFFFF, remainder=opa, div_zero=1.
  - Otherwise go to RUN.
- Multiply init: acc=0, mc=opa, mp=opb.
- Divide init: q=opa, rem=0, d=opb.
- RUN: alu_req=1. One iteration completes on each cycle with alu_gnt=1. Cycles with alu_gnt=0 hold all state; alu_in_*/alu_op keep driving their values (ignored by the ALU mux).
- Multiply iteration:
  - alu_in_0=acc, alu_in_1=mc, alu_op=ALU_OP_ADDU.
  - If mp[0], acc<=alu_out.
  - mc<=mc<<1; mp<=mp>>1 (local shifts, no ALU).
  - Overflow above WIDTH bits is discarded.
- Divide iteration (restoring):
  - t={rem[WIDTH-2:0],q[WIDTH-1]}; alu_in_0=t, alu_in_1=d, alu_op=ALU_OP_SUBU.
  - If t>=d (local unsigned compare, 33-bit safe: treat rem[WIDTH-1] as an extra MSB of t), then rem<=alu_out and q<={q[WIDTH-2:0],1}.
  - Else rem<=t and q<={q[WIDTH-2:0],0}.
- After the WIDTH-th granted iteration, go to DONE. Outputs load on that edge: result=acc or q; remainder=0 or rem.
- DONE: done=1 for exactly one cycle, then IDLE. result/remainder/div_zero hold until the next accepted start. div_zero clears on the next start.
- Latency with gnt held high: start edge -> WIDTH RUN cycles -> DONE. done is high in cycle WIDTH+1 after start is sampled; divide-by-zero gives done 1 cycle after start.
- start while busy is ignored. Inputs are don't-care outside the start cycle.
- start in the same cycle done is high is ignored (state is DONE, not IDLE).
- alu_out is consumed only in RUN with alu_gnt=1.
- Outside RUN: alu_req=0 and alu_op=ALU_OP_NOP.

Test Plan:
- Reset mid-RUN at iteration 10 -> next cycle busy=0, done=0, alu_req=0, alu_op=NOP, result=0; a fresh start then completes normally.
- mul opa=7, opb=6, gnt=1 -> done 33 cycles after start, result=42, remainder=0, div_zero=0; 32 alu_req cycles.
- mul opa=32'hFFFFFFFF, opb=32'hFFFFFFFF -> result=32'h00000001. Also opa=32'h80000000, opb=2 -> result=0.
- div opa=100, opb=7 -> result=14, remainder=2. Also opa=32'hFFFFFFFF, opb=1 -> result=32'hFFFFFFFF, remainder=0. Also opa=3, opb=32'h80000000 -> result=0, remainder=3.
- div opb=0, opa=55 -> done next cycle, result=32'hFFFFFFFF, remainder=55, div_zero=1, alu_req never asserted.
- mul 100*3 with alu_gnt low on alternating cycles -> done after 32 granted cycles (about 65 cycles), result=300. A start pulsed mid-run is ignored and does not change the result.
